// File: rtl/alu_operand_stage_if.sv
// Decode-side handshake, ALU-side handshake and forwarding buses of alu_operand_stage.
// The stage uses the slave modport; the decode/EX side uses master.
interface alu_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1_addr;
    logic [4:0]      in_rs2_addr;
    logic [4:0]      in_rd_addr;
    logic [3:0]      in_alu_op;
    logic            in_use_pc;
    logic            in_use_imm;
    logic            flush;
    logic            exmem_we;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_data;
    logic            memwb_we;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [3:0]      out_alu_op;
    logic [4:0]      out_rd_addr;
    logic [XLEN-1:0] out_store_data;

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op, in_use_pc, in_use_imm,
               flush, exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
               out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd_addr, out_store_data
    );

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_op, in_use_pc, in_use_imm,
               flush, exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
               out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd_addr, out_store_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: 2-entry skid buffer with operand forwarding and writeback refresh.
// Define ALU_OPSTAGE_FWD_EN to enable forwarding/refresh; otherwise captured rs data is used.
module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [3:0]      alu_op;
        logic            use_pc;
        logic            use_imm;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } buf_state_e;

    entry_t          r_m;
    entry_t          r_s;
    entry_t          w_m_ref;
    entry_t          w_s_ref;
    entry_t          w_in_ent;
    entry_t          w_m_nxt;
    entry_t          w_s_nxt;
    buf_state_e      w_state;
    logic            w_accept;
    logic            w_consume;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

`ifdef ALU_OPSTAGE_FWD_EN
    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] addr);
        return we && (rd == addr) && (addr != 5'd0);
    endfunction
`endif

    assign w_state   = buf_state_e'({r_m.valid, r_s.valid});
    assign w_accept  = bus.in_valid && !r_s.valid;
    assign w_consume = r_m.valid && bus.out_ready;

    // Held entries and the incoming instruction, with writeback results folded in.
    always_comb begin
        // NOTE: every always_comb target gets a full default first so no latch is inferred.
        w_m_ref           = r_m;
        w_s_ref           = r_s;
        w_in_ent          = '0;
        w_in_ent.valid    = 1'b1;
        w_in_ent.pc       = bus.in_pc;
        w_in_ent.rs1_data = bus.in_rs1_data;
        w_in_ent.rs2_data = bus.in_rs2_data;
        w_in_ent.imm      = bus.in_imm;
        w_in_ent.rs1_addr = bus.in_rs1_addr;
        w_in_ent.rs2_addr = bus.in_rs2_addr;
        w_in_ent.rd_addr  = bus.in_rd_addr;
        w_in_ent.alu_op   = bus.in_alu_op;
        w_in_ent.use_pc   = bus.in_use_pc;
        w_in_ent.use_imm  = bus.in_use_imm;
`ifdef ALU_OPSTAGE_FWD_EN
        if (r_m.valid && hit(bus.memwb_we, bus.memwb_rd, r_m.rs1_addr)) w_m_ref.rs1_data = bus.memwb_data;
        if (r_m.valid && hit(bus.memwb_we, bus.memwb_rd, r_m.rs2_addr)) w_m_ref.rs2_data = bus.memwb_data;
        if (r_s.valid && hit(bus.memwb_we, bus.memwb_rd, r_s.rs1_addr)) w_s_ref.rs1_data = bus.memwb_data;
        if (r_s.valid && hit(bus.memwb_we, bus.memwb_rd, r_s.rs2_addr)) w_s_ref.rs2_data = bus.memwb_data;
        if (hit(bus.memwb_we, bus.memwb_rd, bus.in_rs1_addr)) w_in_ent.rs1_data = bus.memwb_data;
        if (hit(bus.memwb_we, bus.memwb_rd, bus.in_rs2_addr)) w_in_ent.rs2_data = bus.memwb_data;
`endif
    end

    always_comb begin
        w_m_nxt = w_m_ref;
        w_s_nxt = w_s_ref;
        if (bus.flush) begin
            w_m_nxt.valid = 1'b0;
            w_s_nxt.valid = 1'b0;
        end else begin
            case (w_state)
                EMPTY: begin
                    if (w_accept) w_m_nxt = w_in_ent;
                end
                ONE: begin
                    if (w_accept && w_consume) w_m_nxt = w_in_ent;
                    else if (w_accept)         w_s_nxt = w_in_ent;
                    else if (w_consume)        w_m_nxt.valid = 1'b0;
                end
                FULL: begin
                    if (w_consume) begin
                        w_m_nxt       = w_s_ref;
                        w_s_nxt.valid = 1'b0;
                    end
                end
                default: begin
                    w_m_nxt.valid = 1'b0;
                    w_s_nxt.valid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: whole entries (payload included) are reset so the outputs read zero after reset.
        if (!rst_n) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            r_m <= w_m_nxt;
            r_s <= w_s_nxt;
        end
    end

    // Source operands of M: EX/MEM beats MEM/WB beats stored data; x0 is always zero.
    always_comb begin
        w_rs1 = r_m.rs1_data;
        w_rs2 = r_m.rs2_data;
`ifdef ALU_OPSTAGE_FWD_EN
        if (hit(bus.exmem_we, bus.exmem_rd, r_m.rs1_addr))      w_rs1 = bus.exmem_data;
        else if (hit(bus.memwb_we, bus.memwb_rd, r_m.rs1_addr)) w_rs1 = bus.memwb_data;
        if (hit(bus.exmem_we, bus.exmem_rd, r_m.rs2_addr))      w_rs2 = bus.exmem_data;
        else if (hit(bus.memwb_we, bus.memwb_rd, r_m.rs2_addr)) w_rs2 = bus.memwb_data;
`endif
        if (r_m.rs1_addr == 5'd0) w_rs1 = '0;
        if (r_m.rs2_addr == 5'd0) w_rs2 = '0;
    end

    assign bus.in_ready       = !r_s.valid;
    assign bus.out_valid      = r_m.valid;
    assign bus.out_a          = r_m.use_pc  ? r_m.pc  : w_rs1;
    assign bus.out_b          = r_m.use_imm ? r_m.imm : w_rs2;
    assign bus.out_store_data = w_rs2;
    assign bus.out_alu_op     = r_m.alu_op;
    assign bus.out_rd_addr    = r_m.rd_addr;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: stimulus pushes expected ALU transfers,
// a negedge monitor pops and compares them on every out_valid & out_ready.
module tb_alu_operand_stage;

`ifdef ALU_OPSTAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(32)) bus ();

    alu_operand_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                              input logic [3:0] op, input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.st = st; e.op = op; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd,
                         input logic upc, input logic [31:0] pc, input logic uimm, input logic [31:0] imm);
        bus.in_alu_op   = op;
        bus.in_rs1_addr = a1;
        bus.in_rs1_data = d1;
        bus.in_rs2_addr = a2;
        bus.in_rs2_data = d2;
        bus.in_rd_addr  = rd;
        bus.in_use_pc   = upc;
        bus.in_pc       = pc;
        bus.in_use_imm  = uimm;
        bus.in_imm      = imm;
        bus.in_valid    = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd,
                        input logic upc, input logic [31:0] pc, input logic uimm, input logic [31:0] imm);
        drive(op, a1, d1, a2, d2, rd, upc, pc, uimm, imm);
        for (int k = 0; k < 16 && !bus.in_ready; k++) begin
            @(posedge clk); #1;
        end
        check("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: every ALU transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got a=%h op=%h rd=%0d want nothing at %0t",
                         bus.out_a, bus.out_alu_op, bus.out_rd_addr, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_a", bus.out_a, e.a);
                check("out_b", bus.out_b, e.b);
                check("out_store_data", bus.out_store_data, e.st);
                check("out_alu_op", {28'd0, bus.out_alu_op}, {28'd0, e.op});
                check("out_rd_addr", {27'd0, bus.out_rd_addr}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.exmem_we   = 1'b0;
        bus.exmem_rd   = 5'd0;
        bus.exmem_data = 32'd0;
        bus.memwb_we   = 1'b0;
        bus.memwb_rd   = 5'd0;
        bus.memwb_data = 32'd0;
        drive(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.in_valid   = 1'b0;

        // Reset state
        idle(2);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_a", bus.out_a, 32'd0);
        check("rst_out_b", bus.out_b, 32'd0);
        check("rst_store", bus.out_store_data, 32'd0);
        check("rst_alu_op", {28'd0, bus.out_alu_op}, 32'd0);
        check("rst_rd", {27'd0, bus.out_rd_addr}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // add 5 + 7, one-cycle latency
        bus.out_ready = 1'b1;
        expect_out(32'd5, 32'd7, 32'd7, 4'b0000, 5'd5);
        send(4'b0000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        check("add_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        idle(1);
        check("add_drained", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back at full throughput
        expect_out(32'd3, 32'd4, 32'd4, 4'b0101, 5'd1);
        expect_out(32'h80, 32'd2, 32'd2, 4'b0110, 5'd2);
        expect_out(32'd1, 32'hFFFF_FFFF, 32'h10, 4'b1001, 5'd3);
        send(4'b0101, 5'd1, 32'd3, 5'd2, 32'd4, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        send(4'b0110, 5'd5, 32'h80, 5'd6, 32'd2, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
        send(4'b1001, 5'd7, 32'd1, 5'd8, 32'h10, 5'd3, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
        check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(1);

        // xor then sra under a 3-cycle stall fill the skid buffer
        bus.out_ready = 1'b0;
        expect_out(32'hF0F0, 32'h0FF0, 32'h0FF0, 4'b0010, 5'd8);
        expect_out(32'h8000_0000, 32'd4, 32'h55, 4'b0111, 5'd9);
        send(4'b0010, 5'd6, 32'hF0F0, 5'd7, 32'h0FF0, 5'd8, 1'b0, 32'd0, 1'b0, 32'd0);
        send(4'b0111, 5'd9, 32'h8000_0000, 5'd10, 32'h55, 5'd9, 1'b0, 32'd0, 1'b1, 32'd4);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        idle(2);
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        idle(2);
        check("skid_drained", {31'd0, bus.out_valid}, 32'd0);

        // EX/MEM wins over MEM/WB for rs1=x3
        bus.out_ready = 1'b0;
        expect_out(FWD ? 32'hAA : 32'd1, 32'd2, 32'd2, 4'b0100, 5'd12);
        send(4'b0100, 5'd3, 32'd1, 5'd11, 32'd2, 5'd12, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.exmem_we = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_data = 32'hAA;
        bus.memwb_we = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'hBB;
        #1;
        check("fwd_priority_a", bus.out_a, FWD ? 32'hAA : 32'd1);
        bus.out_ready = 1'b1;
        idle(1);
        bus.exmem_we = 1'b0;
        bus.memwb_we = 1'b0;

        // Writeback retiring during a stall refreshes the held rs2
        bus.out_ready = 1'b0;
        expect_out(32'h100, FWD ? 32'h1234 : 32'd9, FWD ? 32'h1234 : 32'd9, 4'b0011, 5'd14);
        send(4'b0011, 5'd13, 32'd3, 5'd4, 32'd9, 5'd14, 1'b1, 32'h100, 1'b0, 32'd0);
        bus.memwb_we = 1'b1; bus.memwb_rd = 5'd4; bus.memwb_data = 32'h1234;
        idle(1);
        bus.memwb_we = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        // x0 is zero even when a forwarding source targets it
        bus.exmem_we = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_data = 32'hFFFF_FFFF;
        bus.memwb_we = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'hFFFF_FFFF;
        expect_out(32'd0, 32'd5, 32'd5, 4'b0000, 5'd7);
        send(4'b0000, 5'd0, 32'h77, 5'd2, 32'd5, 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(1);
        bus.exmem_we = 1'b0;
        bus.memwb_we = 1'b0;

        // Flush in FULL with a simultaneous in_valid
        bus.out_ready = 1'b0;
        send(4'b0001, 5'd1, 32'd10, 5'd2, 32'd20, 5'd15, 1'b0, 32'd0, 1'b0, 32'd0);
        send(4'b1000, 5'd1, 32'd11, 5'd2, 32'd21, 5'd16, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(4'b1001, 5'd1, 32'd12, 5'd2, 32'd22, 5'd17, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_full_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_full_ready", {31'd0, bus.in_ready}, 32'd1);

        // Flush in ONE: the accepted-looking incoming instruction is dropped too
        send(4'b0001, 5'd1, 32'd13, 5'd2, 32'd23, 5'd18, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(4'b1000, 5'd1, 32'd14, 5'd2, 32'd24, 5'd19, 1'b0, 32'd0, 1'b0, 32'd0);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_one_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        idle(3);

        // Reset mid-handshake drops both held entries
        bus.out_ready = 1'b0;
        send(4'b0010, 5'd1, 32'd30, 5'd2, 32'd31, 5'd20, 1'b0, 32'd0, 1'b0, 32'd0);
        send(4'b0011, 5'd1, 32'd32, 5'd2, 32'd33, 5'd21, 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_out_a", bus.out_a, 32'd0);
        bus.out_ready = 1'b1;
        idle(3);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
